// File: rtl/ddu_btn_cond.sv
// Push-button conditioning for the debug display unit. Each channel is synchronised, debounced,
// and turned into a clean level, press/release pulses and a hold-to-auto-repeat pulse stream.

module ddu_btn_chan #(
  parameter int DEBOUNCE      = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic rpt_o
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [RW-1:0] RD_END  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RP_END  = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rpt_q, rpt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    state_q, state_d;
  logic          rise, fall;

  // Debounce: any sample that agrees with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end
  end

  assign rise      = level_d & ~level_q;
  assign fall      = ~level_d & level_q;
  assign press_d   = rise;
  assign release_d = fall;

  // Repeat FSM: release wins over a repeat that falls due on the same edge.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          rpt_d   = 1'b1;
          rcnt_d  = R_ONE;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = S_IDLE;
        end else if (rcnt_q == RD_END) begin
          rpt_d   = 1'b1;
          rcnt_d  = R_ONE;
          state_d = S_REPEAT;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      S_REPEAT: begin
        if (fall) begin
          rcnt_d  = '0;
          state_d = S_IDLE;
        end else if (rcnt_q == RP_END) begin
          rpt_d  = 1'b1;
          rcnt_d = R_ONE;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
      rcnt_q    <= '0;
      state_q   <= S_IDLE;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign rpt_o     = rpt_q;

endmodule

module ddu_btn_cond #(
  parameter int NUM_BTN       = 3,
  parameter int DEBOUNCE      = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw_i,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] rpt_o
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    ddu_btn_chan #(
      .DEBOUNCE      (DEBOUNCE),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (btn_raw_i[i]),
      .level_o   (level_o[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i]),
      .rpt_o     (rpt_o[i])
    );
  end

endmodule

// File: doc/ddu_btn_cond.md
Name: ddu_btn_cond

Overview:
Conditions the raw push-buttons that drive the debug display unit (step, inc, dec and similar) before the DDU consumes them. Each channel is synchronised, debounced, and turned into clean level, single-cycle press/release pulses, and a hold-to-auto-repeat pulse stream. The DDU uses the outputs directly: press for single-step, rpt for address inc/dec. This replaces free-running period counters inside the DDU.

Parameters:
NUM_BTN, 3, number of independent button channels.
DEBOUNCE, 1_000_000, consecutive cycles the synchronised input must differ from the current level before the level flips. Minimum 1.
REPEAT_DELAY, 50_000_000, cycles from the press pulse to the first repeat pulse. Minimum 2.
REPEAT_PERIOD, 25_000_000, cycles between subsequent repeat pulses. Minimum 1.

Ports:
clk  input  1  system clock (100 MHz).
rst_n  input  1  reset; asynchronous, active-low.
btn_raw  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
level  output  NUM_BTN  debounced button level.
press  output  NUM_BTN  one-cycle pulse on the debounced rising edge.
release  output  NUM_BTN  one-cycle pulse on the debounced falling edge.
rpt  output  NUM_BTN  one-cycle pulses: on press, then auto-repeat while held.

Behaviour:
- All outputs are registered. Channels are fully independent and have no shared state.
- Reset values:
  - sync flops, level, press, release, rpt = 0.
  - Debounce counters = 0.
  - Repeat counters = 0.
  - Repeat FSM = IDLE.
- Synchroniser: 2-flop chain per channel (sync1, sync2). sync2 is the debounce input.
- Debounce:
  - Each cycle that sync2 != level, cnt increments.
  - Any cycle with sync2 == level clears cnt to 0, so glitches shorter than DEBOUNCE are fully rejected.
  - When sync2 != level and cnt == DEBOUNCE-1: level <= sync2 and cnt <= 0.
  - cnt width is $clog2(DEBOUNCE+1). The counter never wraps.
- Latency: raw is stable from the edge k sample onward, so level changes at edge k+DEBOUNCE+1.
- press / release:
  - Asserted at the same edge that level goes 0->1 / 1->0.
  - Cleared at the next edge.
- Repeat FSM per channel (states IDLE, DELAY, REPEAT):
  - IDLE: on the level 0->1 edge, assert rpt, load rcnt = 1, go to DELAY.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY, assert rpt, load rcnt = 1, go to REPEAT.
  - REPEAT: rcnt increments each cycle. When rcnt == REPEAT_PERIOD, assert rpt and load rcnt = 1.
  - In DELAY or REPEAT, level falling (the release edge) forces IDLE and clears rcnt. No rpt is issued at that edge, even if a repeat was due on the same edge.
- rpt pulse edges: E (the press edge), E+REPEAT_DELAY, then every REPEAT_PERIOD after that, for as long as level stays 1.
- rcnt width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Reset mid-operation returns every channel to the reset state. A button held through reset produces a fresh press/rpt DEBOUNCE+2 edges after rst_n deasserts, which is intended.
- Simultaneous events: press on one channel and release on another in the same cycle are both reported. press and release are never asserted together on one channel.

Test Plan:
(Bench parameters: NUM_BTN=3, DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; edge numbering from the first edge sampling raw=1.)
1. Clean press: btn_raw[0] 0->1 sampled at edge 0, held for 12 cycles → level[0]=1 from edge 5; press[0] and rpt[0] high only in the cycle after edge 5; rpt[0] again at edge 15; no other pulses.
2. Glitch rejection: btn_raw[1] high for 3 cycles, low for 1, high for 3, low → level[1], press[1], rpt[1] never assert.
3. Auto-repeat: btn_raw[2] held for 40 cycles → rpt[2] pulses at edges 5, 15, 20, 25, 30, 35, 40. Release then reaches level[2]=0 at edge 45 with release[2]=1, and no rpt at that edge.
4. Release on a due repeat: hold btn_raw[0] so that level falls exactly at edge 20 → no rpt at edge 20. FSM returns to IDLE, and a new press 10 cycles later yields rpt at its own E and E+10.
5. Reset mid-hold: assert rst_n=0 at edge 12 during a hold on channel 0 → all outputs 0 immediately (asynchronous). After deassert with the button still held: press[0] and rpt[0] at edge DEBOUNCE+2=6 after the first post-reset edge.
6. Concurrency: press channel 0 and release channel 1 aligned to the same edge → press[0]=1 and release[1]=1 in the same cycle, with no cross-channel interaction.
